// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: data width, register indexing and writeback entry layout.
package rv32i_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned NREG      = 32;
   localparam int unsigned REG_IDX_W = 5;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef struct packed {
      reg_idx_t          rd;
      logic [XLEN-1:0]   data;
   } wb_entry_t;

   // x0 is hardwired to zero, so it never takes a write or a scoreboard bit.
   function automatic logic idx_is_real(input reg_idx_t idx);
      return idx != '0;
   endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Load-return buffer: synchronous FIFO of writeback entries with async active-low reset.
module wb_load_fifo
   import rv32i_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic      clk,
   input  logic      resetn,
   input  logic      push,
   input  wb_entry_t push_entry,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output wb_entry_t head
);

   localparam int unsigned AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   wb_entry_t   mem_q [DEPTH];

   logic do_push;
   logic do_pop;

   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage needs no reset; emptiness is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= push_entry;
   end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file writeback port arbiter: ALU results win, loads are buffered, and a
// pending-load scoreboard drives the decode-stage hazard signal.
module reg_writeback_ctrl
   import rv32i_pkg::*;
#(
   parameter int unsigned LQ_DEPTH = 2
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            alu_valid,
   input  reg_idx_t        alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  reg_idx_t        ld_rd,
   input  logic [XLEN-1:0] ld_data,
   input  logic            iss_valid,
   input  logic            iss_is_load,
   input  reg_idx_t        iss_rd,
   input  reg_idx_t        chk_rs1,
   input  reg_idx_t        chk_rs2,
   input  reg_idx_t        chk_rd,
   output logic            hazard,
   output logic            wr_en,
   output reg_idx_t        wr_rd,
   output logic [XLEN-1:0] wr_data,
   output logic [NREG-1:0] pending
);

   logic      fifo_full;
   logic      fifo_empty;
   logic      fifo_push;
   logic      fifo_pop;
   wb_entry_t fifo_head;
   wb_entry_t fifo_in;

   logic            wr_en_d;
   reg_idx_t        wr_rd_d;
   logic [XLEN-1:0] wr_data_d;
   logic            wr_is_load_q, wr_is_load_d;
   logic [NREG-1:0] pending_q, pending_d;

   assign ld_ready  = !fifo_full;
   // Loads to x0 are handshaked and dropped here so they never occupy a slot.
   assign fifo_push = ld_valid && ld_ready && idx_is_real(ld_rd);
   assign fifo_pop  = !alu_valid && !fifo_empty;
   assign fifo_in   = '{rd: ld_rd, data: ld_data};

   wb_load_fifo #(
      .DEPTH (LQ_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .resetn     (resetn),
      .push       (fifo_push),
      .push_entry (fifo_in),
      .pop        (fifo_pop),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .head       (fifo_head)
   );

   always_comb begin
      wr_en_d      = 1'b0;
      wr_rd_d      = wr_rd;
      wr_data_d    = wr_data;
      wr_is_load_d = 1'b0;
      if (alu_valid) begin
         if (idx_is_real(alu_rd)) begin
            wr_en_d   = 1'b1;
            wr_rd_d   = alu_rd;
            wr_data_d = alu_data;
         end
      end else if (!fifo_empty) begin
         wr_en_d      = 1'b1;
         wr_rd_d      = fifo_head.rd;
         wr_data_d    = fifo_head.data;
         wr_is_load_d = 1'b1;
      end
   end

   // Clear first so a same-edge issue to the same register keeps the bit set.
   always_comb begin
      pending_d = pending_q;
      if (wr_en && wr_is_load_q) pending_d[wr_rd] = 1'b0;
      if (iss_valid && iss_is_load && idx_is_real(iss_rd)) pending_d[iss_rd] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_en        <= 1'b0;
         wr_rd        <= '0;
         wr_data      <= '0;
         wr_is_load_q <= 1'b0;
         pending_q    <= '0;
      end else begin
         wr_en        <= wr_en_d;
         wr_rd        <= wr_rd_d;
         wr_data      <= wr_data_d;
         wr_is_load_q <= wr_is_load_d;
         pending_q    <= pending_d;
      end
   end

   assign pending = pending_q;
   assign hazard  = pending_q[chk_rs1] | pending_q[chk_rs2] | pending_q[chk_rd];

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed and randomized bench for reg_writeback_ctrl against a queue-based reference model.
module tb_reg_writeback_ctrl;

   localparam int LQ_DEPTH = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        iss_valid;
   logic        iss_is_load;
   logic [4:0]  iss_rd;
   logic [4:0]  chk_rs1, chk_rs2, chk_rd;
   logic        hazard;
   logic        wr_en;
   logic [4:0]  wr_rd;
   logic [31:0] wr_data;
   logic [31:0] pending;

   reg_writeback_ctrl #(
      .LQ_DEPTH (LQ_DEPTH)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_rd       (ld_rd),
      .ld_data     (ld_data),
      .iss_valid   (iss_valid),
      .iss_is_load (iss_is_load),
      .iss_rd      (iss_rd),
      .chk_rs1     (chk_rs1),
      .chk_rs2     (chk_rs2),
      .chk_rd      (chk_rd),
      .hazard      (hazard),
      .wr_en       (wr_en),
      .wr_rd       (wr_rd),
      .wr_data     (wr_data),
      .pending     (pending)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the buffered loads in arrival order, the set of registers
   // with loads outstanding, and the write the register file sees this cycle.
   int unsigned q_rd[$];
   int unsigned q_data[$];
   bit          busy[32];
   bit          m_wr_en;
   int unsigned m_wr_rd;
   int unsigned m_wr_data;
   bit          m_wr_from_load;
   bit          last_accept;
   int unsigned wr_log[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q_rd.delete();
      q_data.delete();
      foreach (busy[i]) busy[i] = 0;
      m_wr_en        = 0;
      m_wr_rd        = 0;
      m_wr_data      = 0;
      m_wr_from_load = 0;
   endtask

   function automatic logic [31:0] busy_vec();
      logic [31:0] v = '0;
      foreach (busy[i]) v[i] = busy[i];
      return v;
   endfunction

   // One clock: check combinational outputs before the edge, advance the model, then
   // check the registered outputs just after the edge.
   task automatic tick();
      bit room, acc, hz;
      #1;
      room = q_rd.size() < LQ_DEPTH;
      hz   = (chk_rs1 != 0 && busy[chk_rs1]) || (chk_rs2 != 0 && busy[chk_rs2]) ||
             (chk_rd != 0 && busy[chk_rd]);
      chk("ld_ready", ld_ready, room);
      chk("hazard", hazard, hz);
      acc = ld_valid && room;
      last_accept = acc;
      // A load write that is on the port this cycle retires its register at this edge.
      if (m_wr_en && m_wr_from_load) busy[m_wr_rd] = 0;
      if (iss_valid && iss_is_load && iss_rd != 0) busy[iss_rd] = 1;
      m_wr_en        = 0;
      m_wr_from_load = 0;
      if (alu_valid) begin
         if (alu_rd != 0) begin
            m_wr_en   = 1;
            m_wr_rd   = alu_rd;
            m_wr_data = alu_data;
         end
      end else if (q_rd.size() > 0) begin
         m_wr_en        = 1;
         m_wr_from_load = 1;
         m_wr_rd        = q_rd.pop_front();
         m_wr_data      = q_data.pop_front();
      end
      if (acc && ld_rd != 0) begin
         q_rd.push_back(ld_rd);
         q_data.push_back(ld_data);
      end
      @(posedge clk);
      #1;
      chk("wr_en", wr_en, m_wr_en);
      chk("wr_rd", wr_rd, m_wr_rd);
      chk("wr_data", wr_data, m_wr_data);
      chk("pending", pending, busy_vec());
      if (wr_en) wr_log.push_back(wr_rd);
   endtask

   task automatic idle_inputs();
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      ld_valid = 0; ld_rd = 0; ld_data = 0;
      iss_valid = 0; iss_is_load = 0; iss_rd = 0;
      chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
   endtask

   initial begin
      idle_inputs();
      model_reset();
      resetn = 0;
      #2;
      chk("rst_wr_en", wr_en, 0);
      chk("rst_pending", pending, 0);
      chk("rst_ld_ready", ld_ready, 1);
      chk("rst_hazard", hazard, 0);
      @(posedge clk);
      #3 resetn = 1;

      // Reset mid-load: two loads buffered behind a busy ALU, then reset.
      alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
      iss_valid = 1; iss_is_load = 1; iss_rd = 5;
      ld_valid = 1; ld_rd = 5; ld_data = 32'hAAAA0001;
      tick();
      iss_rd = 6; ld_rd = 6; ld_data = 32'hAAAA0002;
      tick();
      idle_inputs();
      chk_rs1 = 5; chk_rs2 = 6;
      #2 resetn = 0;
      #1;
      chk("midrst_wr_en", wr_en, 0);
      chk("midrst_pending", pending, 0);
      chk("midrst_ld_ready", ld_ready, 1);
      chk("midrst_hazard", hazard, 0);
      model_reset();
      @(posedge clk);
      #3 resetn = 1;
      wr_log.delete();
      for (int i = 0; i < 4; i++) tick();
      chk("midrst_no_writes", wr_log.size(), 0);

      // ALU only.
      alu_valid = 1; alu_rd = 3; alu_data = 32'h12345678;
      tick();
      chk("alu_x3_en", wr_en, 1);
      chk("alu_x3_rd", wr_rd, 3);
      chk("alu_x3_data", wr_data, 32'h12345678);
      alu_rd = 0; alu_data = 32'hFFFF0000;
      tick();
      chk("alu_x0_en", wr_en, 0);
      idle_inputs();
      tick();

      // Priority and backpressure: ALU busy for 4 cycles, three loads offered.
      wr_log.delete();
      alu_valid = 1; alu_rd = 1;
      ld_valid = 1; ld_rd = 7; ld_data = 32'h1;
      for (int i = 0; i < 4; i++) begin
         alu_data = i;
         if (i == 2) chk("bp_ready_low", ld_ready, 0);
         tick();
         if (last_accept) begin
            if (ld_rd == 7) begin ld_rd = 8; ld_data = 32'h2; end
            else if (ld_rd == 8) begin ld_rd = 9; ld_data = 32'h3; end
            else ld_valid = 0;
         end
      end
      alu_valid = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (last_accept) ld_valid = 0;
      end
      chk("bp_nwrites", wr_log.size(), 7);
      if (wr_log.size() == 7) begin
         chk("bp_order0", wr_log[4], 7);
         chk("bp_order1", wr_log[5], 8);
         chk("bp_order2", wr_log[6], 9);
      end

      // Scoreboard: load to x10, hazard until the register file captures it.
      idle_inputs();
      iss_valid = 1; iss_is_load = 1; iss_rd = 10;
      tick();
      idle_inputs();
      chk_rs2 = 10;
      chk("sb_pending10", pending[10], 1);
      tick();
      ld_valid = 1; ld_rd = 10; ld_data = 32'hDEADBEEF;
      tick();
      ld_valid = 0;
      tick();
      chk("sb_wr_deadbeef", wr_data, 32'hDEADBEEF);
      chk("sb_hazard_at_write", hazard, 1);
      tick();
      chk("sb_hazard_cleared", hazard, 0);

      // Set/clear collision on x4.
      idle_inputs();
      iss_valid = 1; iss_is_load = 1; iss_rd = 4;
      tick();
      iss_valid = 0;
      ld_valid = 1; ld_rd = 4; ld_data = 32'h44;
      tick();
      ld_valid = 0;
      tick();
      chk("col_write_x4", wr_rd, 4);
      iss_valid = 1;
      tick();
      chk("col_pending4", pending[4], 1);
      idle_inputs();
      tick();

      // Load to x0 is accepted and dropped.
      iss_valid = 1; iss_is_load = 1; iss_rd = 0;
      ld_valid = 1; ld_rd = 0; ld_data = 32'h55;
      tick();
      chk("x0_accepted", last_accept, 1);
      idle_inputs();
      tick();
      chk("x0_no_write", wr_en, 0);
      chk("x0_pending", pending[0], 0);
      chk("x0_hazard", hazard, 0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         alu_valid   = ($urandom_range(0, 99) < 45);
         alu_rd      = $urandom_range(0, 31);
         alu_data    = $urandom;
         ld_valid    = ($urandom_range(0, 99) < 50);
         ld_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         ld_data     = $urandom;
         iss_valid   = $urandom_range(0, 1);
         iss_is_load = $urandom_range(0, 1);
         iss_rd      = $urandom_range(0, 31);
         chk_rs1     = $urandom_range(0, 31);
         chk_rs2     = $urandom_range(0, 31);
         chk_rd      = $urandom_range(0, 31);
         tick();
      end
      idle_inputs();
      for (int i = 0; i < 4; i++) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
